// File: rtl/movimento_seq.sv
// Walking-sprite animation across a row of seven-segment digits.
// Advances come from a programmable prescaler (run) or from step-button edges.

module movimento_seq_digit #(
  parameter int PW       = 2,
  parameter int IDX      = 0,
  parameter bit ACT_LOW  = 1'b1
) (
  input  logic [PW-1:0] i_pos,
  input  logic          i_frame,
  output logic [6:0]    o_seg
);
  localparam logic [6:0]    G0  = 7'b1100011;
  localparam logic [6:0]    G1  = 7'b0011101;
  localparam logic [PW-1:0] ME  = PW'(IDX);

  logic [6:0] w_glyph;

  always_comb begin
    w_glyph = 7'b0;
    if (i_pos == ME) w_glyph = i_frame ? G1 : G0;
  end

  assign o_seg = ACT_LOW ? ~w_glyph : w_glyph;
endmodule

module movimento_seq #(
  parameter int DIGITS         = 4,
  parameter int DIV_W          = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  localparam int PW            = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clkd,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step,
  input  logic [1:0]            mode,
  input  logic [DIV_W-1:0]      speed,
  output logic [7*DIGITS-1:0]   seg,
  output logic [DIGITS-1:0]     dp,
  output logic [PW-1:0]         pos,
  output logic                  frame,
  output logic                  tick
);
  localparam logic [0:0]    ST_IDLE = 1'b0;
  localparam logic [0:0]    ST_RUN  = 1'b1;
  localparam logic [PW-1:0] LAST    = PW'(DIGITS - 1);

  logic [0:0]       r_state;
  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;
  logic [PW-1:0]    r_pos;
  logic             r_frame;
  logic             r_dir;      // 0 = moving right, 1 = moving left
  logic             r_step_q;

  logic [PW-1:0]    w_pos_nxt;
  logic             w_dir_nxt;
  logic [DIV_W-1:0] w_cnt_inc;

  always_comb begin
    w_pos_nxt = r_pos;
    w_dir_nxt = r_dir;
    case (mode)
      2'b00: w_pos_nxt = (r_pos == LAST) ? '0 : r_pos + 1'b1;
      2'b01: w_pos_nxt = (r_pos == '0) ? LAST : r_pos - 1'b1;
      2'b10: begin
        if (DIGITS > 1) begin
          if (!r_dir) begin
            if (r_pos == LAST) begin
              w_dir_nxt = 1'b1;
              w_pos_nxt = LAST - 1'b1;
            end else begin
              w_pos_nxt = r_pos + 1'b1;
            end
          end else begin
            if (r_pos == '0) begin
              w_dir_nxt = 1'b0;
              w_pos_nxt = PW'(1);
            end else begin
              w_pos_nxt = r_pos - 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // A committed tick clears the prescaler, so cnt never wraps even if speed drops.
  assign w_cnt_inc = r_tick ? '0 : r_cnt + 1'b1;

  always_ff @(posedge clkd) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_tick   <= 1'b0;
      r_pos    <= '0;
      r_frame  <= 1'b0;
      r_dir    <= 1'b0;
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= step;
      r_tick   <= 1'b0;
      // The advance flagged by tick lands one edge later.
      if (r_tick) begin
        r_pos   <= w_pos_nxt;
        r_dir   <= w_dir_nxt;
        r_frame <= ~r_frame;
      end
      case (r_state)
        ST_IDLE: begin
          if (run) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_tick  <= (speed == '0);
          end else if (step && !r_step_q) begin
            r_tick <= 1'b1;
          end
        end
        default: begin
          if (!run) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt  <= w_cnt_inc;
            r_tick <= (w_cnt_inc >= speed);
          end
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
    movimento_seq_digit #(
      .PW      (PW),
      .IDX     (gi),
      .ACT_LOW (SEG_ACTIVE_LOW)
    ) u_dig (
      .i_pos   (r_pos),
      .i_frame (r_frame),
      .o_seg   (seg[7*gi +: 7])
    );
  end

  assign dp    = SEG_ACTIVE_LOW ? '1 : '0;
  assign pos   = r_pos;
  assign frame = r_frame;
  assign tick  = r_tick;
endmodule

// File: tb/tb_movimento_seq.sv
// Bench for movimento_seq: directed vector table, hand sequences for
// multi-cycle corners, and random stimulus against a behavioural model.
module tb_movimento_seq;
  localparam int D  = 4;
  localparam int DW = 8;
  localparam int PW = 2;

  logic            clkd = 1'b0;
  logic            reset, run, step;
  logic [1:0]      mode;
  logic [DW-1:0]   speed;
  logic [7*D-1:0]  seg;
  logic [D-1:0]    dp;
  logic [PW-1:0]   pos;
  logic            frame, tick;

  always #5 clkd = ~clkd;

  movimento_seq #(.DIGITS(D), .DIV_W(DW), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clkd(clkd), .reset(reset), .run(run), .step(step), .mode(mode),
    .speed(speed), .seg(seg), .dp(dp), .pos(pos), .frame(frame), .tick(tick)
  );

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  bit m_run, m_tick, m_frame, m_stepq;
  int m_elapsed, m_pos, m_dir;

  typedef struct {
    bit       rst;
    bit       run;
    bit [1:0] mode;
    bit [7:0] speed;
    int       e_pos;
    bit       e_frame;
    bit       e_tick;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit r, bit rn, bit [1:0] md, bit [7:0] sp, int p, bit f, bit t);
    vec_t v;
    v.rst = r; v.run = rn; v.mode = md; v.speed = sp;
    v.e_pos = p; v.e_frame = f; v.e_tick = t;
    tbl.push_back(v);
  endfunction

  function automatic logic [7*D-1:0] exp_seg(int p, bit f);
    logic [6:0]     g;
    logic [7*D-1:0] v;
    v = '0;
    for (int i = 0; i < D; i++) begin
      g = (i == p) ? (f ? 7'b0011101 : 7'b1100011) : 7'b0000000;
      v[7*i +: 7] = ~g;
    end
    return v;
  endfunction

  task automatic model_step();
    bit t_next;
    t_next = 1'b0;
    if (reset) begin
      m_run = 0; m_elapsed = 0; m_tick = 0; m_pos = 0;
      m_frame = 0; m_dir = 1; m_stepq = 0;
      return;
    end
    if (m_tick) begin
      m_frame = !m_frame;
      case (mode)
        2'b00: m_pos = (m_pos + 1) % D;
        2'b01: m_pos = (m_pos + D - 1) % D;
        2'b10: begin
          if (m_dir > 0 && m_pos == D - 1)  begin m_dir = -1; m_pos = D - 2; end
          else if (m_dir < 0 && m_pos == 0) begin m_dir = 1;  m_pos = 1;     end
          else m_pos = m_pos + m_dir;
        end
        default: ;
      endcase
    end
    if (!m_run) begin
      if (run) begin m_run = 1; m_elapsed = 0; t_next = (speed == 0); end
      else if (step && !m_stepq) t_next = 1'b1;
    end else if (!run) begin
      m_run = 0;
    end else begin
      m_elapsed = m_tick ? 0 : m_elapsed + 1;
      t_next = (m_elapsed >= int'(speed));
    end
    m_stepq = step;
    m_tick  = t_next;
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clkd);
    model_step();
    @(negedge clkd);
  endtask

  task automatic check_model();
    check("m_pos",   64'(pos),   64'(m_pos));
    check("m_frame", 64'(frame), 64'(m_frame));
    check("m_tick",  64'(tick),  64'(m_tick));
    check("m_seg",   64'(seg),   64'(exp_seg(m_pos, m_frame)));
    check("m_dp",    64'(dp),    64'(4'hF));
  endtask

  int tcnt;

  initial begin
    reset = 1; run = 0; step = 0; mode = 2'b00; speed = '0;
    @(negedge clkd);
    cyc();
    check("rst_seg",   64'(seg),   64'({7'h7F, 7'h7F, 7'h7F, 7'h1C}));
    check("rst_dp",    64'(dp),    64'(4'hF));
    check("rst_pos",   64'(pos),   64'(0));
    check("rst_frame", 64'(frame), 64'(0));
    check("rst_tick",  64'(tick),  64'(0));

    // wrap-right, speed 2
    add(1, 0, 2'b00, 8'd0, 0, 0, 0);
    add(0, 1, 2'b00, 8'd2, 0, 0, 0); add(0, 1, 2'b00, 8'd2, 0, 0, 0);
    add(0, 1, 2'b00, 8'd2, 0, 0, 1); add(0, 1, 2'b00, 8'd2, 1, 1, 0);
    add(0, 1, 2'b00, 8'd2, 1, 1, 0); add(0, 1, 2'b00, 8'd2, 1, 1, 1);
    add(0, 1, 2'b00, 8'd2, 2, 0, 0); add(0, 1, 2'b00, 8'd2, 2, 0, 0);
    add(0, 1, 2'b00, 8'd2, 2, 0, 1); add(0, 1, 2'b00, 8'd2, 3, 1, 0);
    add(0, 1, 2'b00, 8'd2, 3, 1, 0); add(0, 1, 2'b00, 8'd2, 3, 1, 1);
    add(0, 1, 2'b00, 8'd2, 0, 0, 0);
    // bounce, speed 0
    add(1, 0, 2'b10, 8'd0, 0, 0, 0);
    add(0, 1, 2'b10, 8'd0, 0, 0, 1); add(0, 1, 2'b10, 8'd0, 1, 1, 1);
    add(0, 1, 2'b10, 8'd0, 2, 0, 1); add(0, 1, 2'b10, 8'd0, 3, 1, 1);
    add(0, 1, 2'b10, 8'd0, 2, 0, 1); add(0, 1, 2'b10, 8'd0, 1, 1, 1);
    add(0, 1, 2'b10, 8'd0, 0, 0, 1); add(0, 1, 2'b10, 8'd0, 1, 1, 1);
    add(0, 1, 2'b10, 8'd0, 2, 0, 1);
    // wrap-left, speed 0
    add(1, 0, 2'b01, 8'd0, 0, 0, 0);
    add(0, 1, 2'b01, 8'd0, 0, 0, 1); add(0, 1, 2'b01, 8'd0, 3, 1, 1);
    add(0, 1, 2'b01, 8'd0, 2, 0, 1); add(0, 1, 2'b01, 8'd0, 1, 1, 1);
    add(0, 1, 2'b01, 8'd0, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; run = tbl[i].run; mode = tbl[i].mode; speed = tbl[i].speed;
      cyc();
      check("tbl_pos",   64'(pos),   64'(tbl[i].e_pos));
      check("tbl_frame", 64'(frame), 64'(tbl[i].e_frame));
      check("tbl_tick",  64'(tick),  64'(tbl[i].e_tick));
      check("tbl_seg",   64'(seg),   64'(exp_seg(tbl[i].e_pos, tbl[i].e_frame)));
      if (i == 4) check("digit1_g1", 64'(seg[13:7]), 64'(7'h62));
    end

    // step mode: held level gives one advance, a second press gives another
    reset = 1; run = 0; mode = 2'b00; cyc();
    reset = 0; tcnt = 0;
    for (int c = 0; c < 12; c++) begin
      step = (c < 5) || (c == 8);
      cyc();
      if (tick) tcnt++;
    end
    check("step_ticks", 64'(tcnt), 64'(2));
    check("step_pos",   64'(pos),  64'(2));

    // step edges ignored while running
    run = 1; speed = 8'd3; tcnt = 0;
    for (int c = 0; c < 20; c++) begin
      step = c[0];
      cyc();
      if (tick) tcnt++;
    end
    check("run_step_ticks", 64'(tcnt), 64'(5));
    step = 0;

    // lowering speed below the running count fires on the next cycle
    reset = 1; run = 0; cyc();
    reset = 0; run = 1; speed = 8'd200; tcnt = 0;
    for (int c = 0; c < 151; c++) begin
      cyc();
      if (tick) tcnt++;
    end
    check("slow_no_tick", 64'(tcnt), 64'(0));
    speed = 8'd10;
    cyc();
    check("lower_tick", 64'(tick), 64'(1));
    for (int r = 0; r < 2; r++)
      for (int j = 1; j <= 11; j++) begin
        cyc();
        if (tick !== (j == 11)) check("period11_tick", 64'(tick), 64'(j == 11));
        else if (j == 11) check("period11_tick", 64'(tick), 64'(1));
      end

    // hold mode, then reset with an advance pending
    reset = 1; run = 0; cyc();
    reset = 0; run = 1; mode = 2'b11; speed = 8'd1;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      check("hold_pos",   64'(pos),   64'(0));
      check("hold_frame", 64'(frame), 64'((c == 3 || c == 4) ? 1 : 0));
      check("hold_tick",  64'(tick),  64'(c % 2 == 0));
    end
    reset = 1; cyc();
    check("midrst_tick", 64'(tick), 64'(0));
    check("midrst_seg",  64'(seg),  64'({7'h7F, 7'h7F, 7'h7F, 7'h1C}));
    reset = 0; run = 0; cyc();
    check("midrst_frame", 64'(frame), 64'(0));
    check("midrst_pos",   64'(pos),   64'(0));

    // randomized against the model
    mode = 2'b00; speed = 8'd1;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(99) == 0);
      if ($urandom_range(39) == 0) run = ~run;
      step = ($urandom_range(2) == 0);
      if ($urandom_range(29) == 0) mode  = 2'($urandom_range(3));
      if ($urandom_range(24) == 0) speed = 8'($urandom_range(5));
      cyc();
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/movimento_seq.md
Name: movimento_seq

Overview:
- Parametrised successor to the single-digit walking-dog animation.
- Drives a sprite across a row of DIGITS seven-segment digits. The sprite alternates between two leg glyphs on every advance.
- Advances come from an internal programmable prescaler (free-run) or from a debounced button edge (single-step).
- Selectable motion mode: wrap-right, wrap-left, bounce or hold. Sits between the board clock domain and the display pins.

Parameters:
- DIGITS, 4, number of digits in the row (>=1).
- DIV_W, 8, width of the speed/prescaler counter.
- SEG_ACTIVE_LOW, 1, 1 inverts all segment and dp outputs (common-anode boards).

Ports:
- clkd  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = free-run animation, 0 = stopped/step mode.
- step  in  1  button level (already debounced); rising edge = one advance when stopped.
- mode  in  2  00 wrap-right, 01 wrap-left, 10 bounce, 11 hold.
- speed  in  DIV_W  advance period in free-run = speed+1 clkd cycles.
- seg  out  7*DIGITS  digit i occupies bits [7i+6:7i], order a,b,c,d,e,f,g (bit 7i+6 = a).
- dp  out  DIGITS  decimal points, always off.
- pos  out  PW  sprite digit index; PW = clog2(DIGITS), minimum 1.
- frame  out  1  current glyph select.
- tick  out  1  one-cycle pulse in the cycle an advance is committed.

Behaviour:
- Glyphs (active-high, abcdefg): G0 = 1100011 (a,b,f,g), G1 = 0011101 (c,d,e,g). Blank = 0000000.
- Digit pos shows G[frame]; all other digits are blank. Active-high dp is 0.
- With SEG_ACTIVE_LOW=1, the outputs are bitwise inverted.
- All outputs are registered or derived from registers only; no combinational path from inputs.
- Reset (sync, priority over everything): state=IDLE, pos=0, frame=0, dir=right, cnt=0, step_q=0, tick=0.
- Reset outputs with DIGITS=4, active-low: seg = 7F,7F,7F,1C hex (digit3..digit0), dp = 4'hF.
- FSM, two states:
  - IDLE: run=1 -> RUN with cnt cleared. Otherwise, a step edge (step & ~step_q) causes an advance: tick=1 that cycle, new pos/frame visible the next cycle.
  - RUN: cnt increments each cycle. When cnt >= speed: tick=1, cnt<=0, advance. run=0 -> IDLE; cnt is not used in IDLE, and no advance occurs in the cycle run drops.
- step_q samples step every cycle in both states. Step edges while in RUN are ignored.
- Latency: run rises at cycle 0 -> RUN from edge 1 -> first tick at cycle speed+1 -> advanced outputs from cycle speed+2. Advances then repeat every speed+1 cycles.
- speed=0: advance every cycle.
- speed lowered below the current cnt: the >= compare fires a tick on the next cycle, with no wrap through 2^DIV_W.
- Advance always toggles frame. Position rule per mode:
  - 00: pos = (pos+1) mod DIGITS.
  - 01: pos = (pos-1) mod DIGITS (0 -> DIGITS-1).
  - 10: moving right at pos=DIGITS-1 -> dir=left, pos=DIGITS-2. Moving left at pos=0 -> dir=right, pos=1. Otherwise pos +/- 1 per dir. DIGITS=1: pos stays 0.
  - 11: pos unchanged, frame still toggles.
- Mode change takes effect on the next advance; dir is retained across mode changes. pos is never out of range.
- Reset asserted mid-run or mid-step restores the reset state on the next edge; tick is 0 in that cycle.

Test Plan:
- Reset, DIGITS=4, SEG_ACTIVE_LOW=1 -> seg = 7F7F7F1C (digit3..digit0), dp = F, pos = 0, frame = 0, tick = 0.
- run=1, mode=00, speed=2 -> tick every 3 cycles, first tick at cycle 3. pos goes 1,2,3,0 with frame 1,0,1,0. After the first tick, digit1 = 62 hex.
- run=1, mode=10, speed=0 -> pos per cycle 1,2,3,2,1,0,1,2 and frame alternates each cycle.
- run=0, step held high 5 cycles, then low, then high 1 cycle -> exactly two ticks (pos 0->1->2). Step pulses while run=1 produce no extra ticks.
- run=1, speed=200, wait until cnt=150, then set speed=10 -> tick on the next cycle, then every 11 cycles.
- run=1, mode=11, speed=1 -> pos stays 0 and frame toggles every 2 cycles. Assert reset mid-sequence -> next cycle equals the reset values and no tick that cycle.
